nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-precision adder/subtractor controller that sequences a single 4-bit carry-in/carry-out add slice over a WIDTH-bit operand pair, one nibble per clock, least-significant nibble first. It carries the inter-nibble carry in a register. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides, and is the team's area-cheap alternative to a full-width ripple-carry adder.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 8; NIB = WIDTH/4 nibble steps per operation.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair and op are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A, two's complement or unsigned.
- b  input  WIDTH  operand B.
- sub  input  1  0: A+B, 1: A−B.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- overflow  output  1  signed overflow.
- busy  output  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture a, b and sub into internal registers.
  - Set the carry register to sub, set nibble index to 0, clear the sum register, and go to RUN.
- RUN:
  - Each cycle, add nibble[idx] of A, nibble[idx] of (B XOR {WIDTH{sub}}) and the carry register in the 4-bit slice.
  - Write the 4-bit result into sum[4*idx+3:4*idx], store the slice carry-out in the carry register, and increment idx.
  - On the step with idx=NIB−1:
    - carry ← slice carry-out.
    - overflow ← (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1).
    - Go to DONE.
- DONE:
  - out_valid=1.
  - sum, carry and overflow are held stable until out_valid&out_ready.
  - Then go to IDLE.
- in_ready=0 in RUN and DONE; in_valid is ignored there.
- There is no input-to-output bypass. A new operation is accepted at the earliest one cycle after the result handshake.
- sum shows partial nibbles during RUN and is meaningful only while out_valid=1. After the handshake, sum, carry and overflow retain their values until the next acceptance clears them.
- Arithmetic is modulo 2^WIDTH. carry and overflow are both reported; the consumer chooses the unsigned or signed interpretation.

## Timing
- Reset (rst_n low, asynchronous, any state):
  - State = IDLE.
  - in_ready=1 once rst_n is low, as a function of the IDLE state.
  - out_valid=0, busy=0, sum=0, carry=0, overflow=0.
  - Internal operand, carry and index registers = 0.
- Reset asserted mid-RUN or mid-DONE aborts the operation; no result is produced.
- Latency: operation accepted at edge k → RUN occupies edges k+1 … k+NIB → out_valid=1 after edge k+NIB.
  - With WIDTH=16, out_valid rises 4 cycles after acceptance.
- With out_ready held high, the throughput is one operation per NIB+2 cycles.
- out_valid stays high indefinitely under out_ready=0; no result is dropped or overwritten.
- busy = (state≠IDLE), equivalent to !in_ready.

## Test plan
All scenarios use WIDTH=16.
- a=0x0006, b=0x000F, sub=0 → sum=0x0015, carry=0, overflow=0; out_valid rises exactly 4 cycles after the in_valid&in_ready edge.
- a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, carry=0, overflow=1. Then a=0xFFFF, b=0x0001, sub=0 → sum=0x0000, carry=1, overflow=0.
- Subtract cases:
  - a=0x0003, b=0x0005, sub=1 → sum=0xFFFE, carry=0, overflow=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, carry=1, overflow=1.
- Backpressure: after a=0x1234, b=0x4321, sub=0 completes, hold out_ready=0 for 5 cycles while driving in_valid=1 with other operands.
  - out_valid stays 1 and sum stays 0x5555.
  - in_ready stays 0 and the second operation is not accepted.
  - After out_ready=1, in_ready=1 on the next cycle and the second operation is then accepted and computed correctly.
- Reset mid-operation: start a=0xFFFF, b=0xFFFF, then pull rst_n low 2 cycles into RUN.
  - All outputs immediately go to their reset values, with in_ready=1 and out_valid=0.
  - After release, a=0x00FF, b=0x0F01, sub=0 → sum=0x1000, carry=0, overflow=0, with no residue from the aborted operation.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Multi-precision adder/subtractor: one 4-bit add slice sequenced over WIDTH bits,
// least-significant nibble first, with valid/ready handshakes on both sides.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             sub_q, sub_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [3:0] a_nib, b_nib;
  logic [4:0] slice;
  logic [3:0] low3;

  function automatic logic [4:0] add4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
  endfunction

  // Carry into the nibble's top bit: needed only on the MSB nibble for signed overflow.
  function automatic logic [3:0] add3(input logic [2:0] x, input logic [2:0] y,
                                      input logic ci);
    return {1'b0, x} + {1'b0, y} + {3'b000, ci};
  endfunction

  always_comb begin
    a_nib = a_q[{idx_q, 2'b00} +: 4];
    b_nib = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};
    slice = add4(a_nib, b_nib, cy_q);
    low3  = add3(a_nib[2:0], b_nib[2:0], cy_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    cy_d    = cy_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          cy_d    = sub;
          idx_d   = '0;
          sum_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = slice[3:0];
        cy_d  = slice[4];
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NIB - 1)) begin
          carry_d = slice[4];
          ovf_d   = low3[3] ^ slice[4];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      cy_q    <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      cy_q    <= cy_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder (WIDTH=16) with an
// arithmetic reference model and a per-cycle compare process.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        carry;
  logic        overflow;
  logic        busy;

  int tests = 0;
  int fails = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: {overflow, carry, sum} from plain wide arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s);
    logic [15:0] yx;
    logic [16:0] full;
    logic        v;
    yx   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yx} + {16'd0, s};
    v    = (x[15] == yx[15]) && (full[15] != x[15]);
    return {v, full[16], full[15:0]};
  endfunction

  // Compare process: sampled on the falling edge, pre-edge inputs remembered.
  logic [17:0] q[$];
  logic [17:0] e;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        p_rst = 1'b0, p_iv = 1'b0, p_ir = 1'b0, p_ov = 1'b0, p_or = 1'b0, p_sub = 1'b0;
  logic [15:0] p_a = '0, p_b = '0;

  always @(negedge clk) begin
    cyc++;
    if (p_rst && p_ov && p_or && q.size() > 0) void'(q.pop_front());
    if (p_rst && p_iv && p_ir) begin
      q.push_back(model(p_a, p_b, p_sub));
      acc_cyc = cyc;
    end
    if (!rst_n) begin
      q.delete();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sum", sum, 0);
      chk("rst_carry", carry, 0);
      chk("rst_overflow", overflow, 0);
    end else begin
      chk("busy_vs_in_ready", busy, !in_ready);
      if (out_valid) begin
        chk("in_ready_in_done", in_ready, 0);
        if (q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          e = q[0];
          chk("sum", sum, e[15:0]);
          chk("carry", carry, e[16]);
          chk("overflow", overflow, e[17]);
        end
        if (!p_ov) chk("latency", cyc - acc_cyc, 4);
      end
    end
    p_rst = rst_n; p_iv = in_valid; p_ir = in_ready; p_ov = out_valid;
    p_or = out_ready; p_a = a; p_b = b; p_sub = sub;
  end

  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic s);
    int n;
    in_valid = 1'b1; a = x; b = y; sub = s;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_lit(input string name, input logic [15:0] es, input logic ec,
                          input logic ev);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_out_valid"}, out_valid, 1);
    chk({name, "_sum"}, sum, es);
    chk({name, "_carry"}, carry, ec);
    chk({name, "_ovf"}, overflow, ev);
  endtask

  logic [15:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
  logic        acc;
  int          ops;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'h0006, 16'h000F, 1'b0);
    wait_lit("add_small", 16'h0015, 1'b0, 1'b0);
    @(posedge clk); #1;
    do_op(16'h7FFF, 16'h0001, 1'b0);
    wait_lit("add_ovf", 16'h8000, 1'b0, 1'b1);
    @(posedge clk); #1;
    do_op(16'hFFFF, 16'h0001, 1'b0);
    wait_lit("add_carry", 16'h0000, 1'b1, 1'b0);
    @(posedge clk); #1;
    do_op(16'h0003, 16'h0005, 1'b1);
    wait_lit("sub_borrow", 16'hFFFE, 1'b0, 1'b0);
    @(posedge clk); #1;
    do_op(16'h8000, 16'h0001, 1'b1);
    wait_lit("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
    @(posedge clk); #1;

    // Backpressure: result held, second operation refused until handshake.
    out_ready = 1'b0;
    do_op(16'h1234, 16'h4321, 1'b0);
    wait_lit("bp_first", 16'h5555, 1'b0, 1'b0);
    in_valid = 1'b1; a = 16'h0F0F; b = 16'h0101; sub = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", sum, 16'h5555);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accepted", busy, 1);
    wait_lit("bp_second", 16'h0E0E, 1'b1, 1'b0);
    @(posedge clk); #1;

    // Reset two cycles into RUN aborts the operation.
    do_op(16'hFFFF, 16'hFFFF, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_carry", carry, 0);
    chk("abort_ovf", overflow, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h00FF, 16'h0F01, 1'b0);
    wait_lit("after_abort", 16'h1000, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and idle gaps.
    ops = 0;
    for (int c = 0; c < 3000 && ops < 150; c++) begin
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        ops++;
        in_valid = 1'b0;
      end
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
        b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
        sub = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("drain_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
